mux64_scan_ctrl: RTL and testbench
==================================

# mux64_scan_ctrl

Sequencer that sits directly upstream of the team's 64:1 bit multiplexer (`mux64x1`). It drives the mux's 6-bit select through a programmed channel range and holds each channel for a fixed settle time. It samples the mux output and assembles the bits into a 64-bit snapshot, which it hands downstream with a valid/ready handshake. This block owns all select sequencing; the mux stays purely combinational.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each channel is held on `sel`; sample taken on the last of them; legal range 1..255.

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  scan request; accepted only in IDLE
- `first_ch`  in  6  first channel of scan; latched on accept
- `last_ch`  in  6  last channel of scan; latched on accept
- `mux_out`  in  1  output of `mux64x1`
- `sel`  out  6  select to `mux64x1`
- `snap`  out  64  snapshot; bit i = sampled value of channel i
- `snap_valid`  out  1  snapshot complete and stable
- `snap_ready`  in  1  downstream accepts snapshot
- `busy`  out  1  high whenever state != IDLE
- `cont`  in  1  present only with `MUX64_SCAN_CONT_EN`

## Operation
States: IDLE, SCAN, HOLD.

- **IDLE**
  - On `start`=1: latch `first_ch` and `last_ch`, set `sel`=`first_ch`, clear dwell count, clear `snap` to 0, go to SCAN.
  - Otherwise hold all outputs.
- **SCAN**
  - Dwell counter runs 0..SETTLE_CYCLES-1.
  - When count = SETTLE_CYCLES-1: write `mux_out` into `snap[sel]`.
  - If `sel` = latched last: go to HOLD and keep `sel`.
  - Otherwise `sel` <= `sel`+1, modulo 64, and the count restarts at 0.
- **HOLD**
  - `snap_valid`=1; `snap` and `sel` frozen.
  - On `snap_valid & snap_ready` at a clock edge: go to IDLE.
- Channel count K = ((last − first) mod 64) + 1.
  - first = last: one channel.
  - first > last: wrap, e.g. 62,63,0,1.
  - first=0, last=63: full scan.
- Bits outside the scanned range read 0 in `snap`.
- `start` is ignored in SCAN and HOLD; there is no queueing.
- Reset mid-scan or in HOLD aborts immediately; no partial snapshot is presented.

## Timing
- Reset values: `sel`=0, `snap`=0, `snap_valid`=0, `busy`=0, state IDLE, dwell count 0.
- `start` sampled at edge E0: `sel`=first and `busy`=1 from the cycle after E0.
- Channel j (0-based within the scan) is driven on `sel` from edge E0 + j·SETTLE_CYCLES.
  - It is sampled at edge E0 + (j+1)·SETTLE_CYCLES.
- `snap_valid` rises in the cycle after edge E0 + K·SETTLE_CYCLES.
  - With `snap_ready` held high, it is high for exactly 1 cycle.
- On the handshake edge, state goes to IDLE.
  - `snap_valid` and `busy` are 0 the next cycle.
  - A `start` in that next cycle is accepted, so back-to-back scans lose one idle cycle.
- `snap` never changes while `snap_valid`=1.

## Configuration
- Macro `MUX64_SCAN_CONT_EN`.
- Defined:
  - The `cont` input exists.
  - If `cont`=1 at the handshake edge, go directly to SCAN with the same latched range: `sel`=first, `snap` cleared, no IDLE cycle, `busy` stays 1.
  - If `cont`=0, go to IDLE as normal.
- Undefined:
  - No `cont` port.
  - Every completed handshake returns to IDLE.

## Structure
- Package `mux64_scan_pkg` holds:
  - constants `CH_W`=6 and `N_CH`=64
  - the state enum typedef (IDLE/SCAN/HOLD)
- Sub-module `mux64_dwell_cnt` holds:
  - the settle counter, parameterised by SETTLE_CYCLES
  - `clear` input and `last` (terminal count) output
- The controller FSM, `sel` register and snapshot register live in `mux64_scan_ctrl`.
- The bench instantiates `mux64_scan_ctrl` feeding `mux64x1` with a driven 64-bit pattern.

## Test plan
- Full scan: SETTLE_CYCLES=2, first=0, last=63, pattern 64'hA5A5_0F0F_1234_5678 → after 128 cycles `snap` equals pattern, `snap_valid`=1.
- Wrap range: first=62, last=1, pattern all ones → `snap`=64'hC000_0000_0000_0003; `sel` sequence 62,63,0,1.
- Single channel: first=last=17, SETTLE_CYCLES=1 → `snap_valid` 1 cycle after the sample edge; only bit 17 can be set.
- Backpressure: `snap_ready`=0 for 10 cycles in HOLD → `snap_valid`, `snap` and `sel` stable; `start` pulses ignored; release gives one handshake, then IDLE.
- Reset mid-scan: assert `rst` at channel 30 of a full scan → next cycle `sel`=0, `snap`=0, `busy`=0; a new `start` scans cleanly.
- `MUX64_SCAN_CONT_EN`, `cont`=1: three consecutive snapshots with no IDLE cycle between; `busy` never drops; pattern change between scans is reflected.

Source files
------------

// File: rtl/mux64_scan_ctrl_pkg.sv
// Shared constants and FSM state type for the 64-channel mux scan controller.
package mux64_scan_pkg;
  localparam int CH_W = 6;
  localparam int N_CH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } scan_state_e;
endpackage

// File: rtl/mux64_scan_ctrl_if.sv
// Bus between the scan controller and its requester/consumer; cont exists only
// when MUX64_SCAN_CONT_EN is defined.
interface mux64_scan_ctrl_if;
  import mux64_scan_pkg::*;

  logic            start;
  logic [CH_W-1:0] first_ch;
  logic [CH_W-1:0] last_ch;
  logic            mux_out;
  logic [CH_W-1:0] sel;
  logic [N_CH-1:0] snap;
  logic            snap_valid;
  logic            snap_ready;
  logic            busy;
`ifdef MUX64_SCAN_CONT_EN
  logic            cont;

  modport master (
    output start, first_ch, last_ch, mux_out, snap_ready, cont,
    input  sel, snap, snap_valid, busy
  );
  modport slave (
    input  start, first_ch, last_ch, mux_out, snap_ready, cont,
    output sel, snap, snap_valid, busy
  );
`else
  modport master (
    output start, first_ch, last_ch, mux_out, snap_ready,
    input  sel, snap, snap_valid, busy
  );
  modport slave (
    input  start, first_ch, last_ch, mux_out, snap_ready,
    output sel, snap, snap_valid, busy
  );
`endif
endinterface

// File: rtl/mux64_scan_ctrl_dwell_cnt.sv
// Settle counter: counts 0..SETTLE_CYCLES-1 and wraps; held at 0 while clear.
module mux64_dwell_cnt #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last
);
  localparam logic [7:0] TERM = 8'(SETTLE_CYCLES - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear || last) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign last = (cnt_q == TERM);
endmodule

// File: rtl/mux64x1.sv
// Purely combinational 64:1 bit multiplexer fed by the scan controller's select.
module mux64x1 (
  input  logic [63:0] din,
  input  logic [5:0]  sel,
  output logic        dout
);
  assign dout = din[sel];
endmodule

// File: rtl/mux64_scan_ctrl.sv
// Scans a channel range through mux64x1 and presents a 64-bit snapshot on a
// valid/ready handshake. Define MUX64_SCAN_CONT_EN for continuous rescans via cont.
module mux64_scan_ctrl
  import mux64_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  mux64_scan_ctrl_if.slave   bus
);
  scan_state_e     state_q;
  logic [CH_W-1:0] sel_q;
  logic [CH_W-1:0] last_q;
  logic [N_CH-1:0] snap_q;
  logic            snap_valid_q;
  logic            busy_q;
`ifdef MUX64_SCAN_CONT_EN
  logic [CH_W-1:0] first_q;
`endif

  logic            dwell_last;
  logic [N_CH-1:0] samp_hot;
  logic [N_CH-1:0] snap_d;

  // Counter only runs in SCAN, so it restarts at 0 on every entry.
  mux64_dwell_cnt #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != SCAN),
    .last  (dwell_last)
  );

  genvar gi;
  for (gi = 0; gi < N_CH; gi++) begin : g_hot
    assign samp_hot[gi] = (sel_q == CH_W'(gi));
  end

  assign snap_d = (snap_q & ~samp_hot) | (samp_hot & {N_CH{bus.mux_out}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_q       <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MUX64_SCAN_CONT_EN
      first_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
`ifdef MUX64_SCAN_CONT_EN
            first_q <= bus.first_ch;
`endif
            last_q  <= bus.last_ch;
            sel_q   <= bus.first_ch;
            snap_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (dwell_last) begin
            snap_q <= snap_d;
            if (sel_q == last_q) begin
              state_q      <= HOLD;
              snap_valid_q <= 1'b1;
            end else begin
              sel_q <= sel_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // snap_valid is high for the whole of HOLD, so ready alone completes the handshake.
          if (bus.snap_ready) begin
            snap_valid_q <= 1'b0;
`ifdef MUX64_SCAN_CONT_EN
            if (bus.cont) begin
              sel_q   <= first_q;
              snap_q  <= '0;
              state_q <= SCAN;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
`else
            busy_q  <= 1'b0;
            state_q <= IDLE;
`endif
          end
        end
        default: begin
          state_q      <= IDLE;
          snap_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.snap       = snap_q;
  assign bus.snap_valid = snap_valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mux64_scan_ctrl.sv
// Self-checking bench: two controllers (settle 2 and settle 1) each feeding a mux64x1.
module tb_mux64_scan_ctrl;
  localparam int S_A = 2;

  logic        clk;
  logic        rst;
  logic [63:0] pat;
  logic [63:0] pat1;
  logic [63:0] exp_q[$];
  logic [63:0] last_snap;
  int          n_checks;
  int          n_fail;

  mux64_scan_ctrl_if bus ();
  mux64_scan_ctrl_if bus1 ();

  mux64_scan_ctrl #(.SETTLE_CYCLES(S_A)) dut (.clk(clk), .rst(rst), .bus(bus));
  mux64x1 u_mux (.din(pat), .sel(bus.sel), .dout(bus.mux_out));

  mux64_scan_ctrl #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux64x1 u_mux1 (.din(pat1), .sel(bus1.sel), .dout(bus1.mux_out));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] range_mask(input logic [5:0] f, input logic [5:0] l);
    logic [5:0]  d;
    logic [63:0] m;
    d = l - f;
    m = '0;
    for (int i = 0; i <= int'(d); i++) m[(int'(f) + i) % 64] = 1'b1;
    return m;
  endfunction

  // Start a scan on the settle-2 DUT, follow sel every cycle, check latency and snapshot.
  task automatic run_scan(input logic [5:0] f, input logic [5:0] l, input bit rdy);
    logic [5:0]  d;
    logic [5:0]  es;
    logic [63:0] e;
    int          k;
    int          n;
    d = l - f;
    k = int'(d) + 1;
    exp_q.push_back(pat & range_mask(f, l));
    bus.first_ch = f;
    bus.last_ch  = l;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_busy: busy=%b required 1", bus.busy);
    end
    n = 0;
    while (bus.snap_valid !== 1'b1 && n < k * S_A + 8) begin
      es = 6'(int'(f) + ((n / S_A < k) ? n / S_A : k - 1));
      n_checks++;
      if (bus.sel !== es) begin
        n_fail++;
        $display("FAIL scan_sel: cycle %0d sel=%0d required %0d", n, bus.sel, es);
      end
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != k * S_A) begin
      n_fail++;
      $display("FAIL scan_latency: valid after %0d cycles required %0d", n, k * S_A);
    end
    e = exp_q.pop_front();
    last_snap = bus.snap;
    n_checks++;
    if (bus.snap !== e) begin
      n_fail++;
      $display("FAIL scan_snap: snap=%h required %h", bus.snap, e);
    end
    n_checks++;
    if (bus.sel !== l) begin
      n_fail++;
      $display("FAIL hold_sel: sel=%0d required %0d", bus.sel, l);
    end
    $display("scan first=%0d last=%0d K=%0d latency=%0d snap=%h", f, l, k, n, bus.snap);
    if (rdy) begin
      @(negedge clk);
      n_checks++;
      if (bus.snap_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_handshake: valid=%b busy=%b required 0 0", bus.snap_valid, bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.sel !== 6'd0 || bus.snap !== 64'd0 || bus.snap_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: sel=%0d snap=%h valid=%b busy=%b required 0 0 0 0",
               bus.sel, bus.snap, bus.snap_valid, bus.busy);
    end
    n_checks++;
    if (bus1.sel !== 6'd0 || bus1.snap !== 64'd0 || bus1.snap_valid !== 1'b0 || bus1.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state1: sel=%0d snap=%h valid=%b busy=%b required 0 0 0 0",
               bus1.sel, bus1.snap, bus1.snap_valid, bus1.busy);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset done");
  endtask

  task automatic test_full_scan();
    pat = 64'hA5A5_0F0F_1234_5678;
    bus.snap_ready = 1'b1;
    run_scan(6'd0, 6'd63, 1'b1);
    n_checks++;
    if (last_snap !== 64'hA5A5_0F0F_1234_5678) begin
      n_fail++;
      $display("FAIL full_snap_const: snap=%h required a5a50f0f12345678", last_snap);
    end
  endtask

  task automatic test_wrap();
    pat = '1;
    run_scan(6'd62, 6'd1, 1'b1);
    n_checks++;
    if (last_snap !== 64'hC000_0000_0000_0003) begin
      n_fail++;
      $display("FAIL wrap_snap_const: snap=%h required c000000000000003", last_snap);
    end
  endtask

  task automatic test_back_to_back();
    pat = 64'h0123_4567_89AB_CDEF;
    run_scan(6'd10, 6'd20, 1'b1);
    pat = 64'hFEDC_BA98_7654_3210;
    run_scan(6'd40, 6'd45, 1'b1);
    pat = 64'hDEAD_BEEF_CAFE_F00D;
    run_scan(6'd33, 6'd33, 1'b1);
  endtask

  task automatic test_single_channel();
    logic [63:0] e;
    bus1.snap_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      pat1 = (t == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFD_FFFF;
      exp_q.push_back(pat1 & range_mask(6'd17, 6'd17));
      bus1.first_ch = 6'd17;
      bus1.last_ch  = 6'd17;
      bus1.start    = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      n_checks++;
      if (bus1.sel !== 6'd17 || bus1.busy !== 1'b1 || bus1.snap_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_scan: sel=%0d busy=%b valid=%b required 17 1 0",
                 bus1.sel, bus1.busy, bus1.snap_valid);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (bus1.snap_valid !== 1'b1 || bus1.snap !== e) begin
        n_fail++;
        $display("FAIL single_snap: valid=%b snap=%h required 1 %h", bus1.snap_valid, bus1.snap, e);
      end
      $display("single channel 17 pass %0d snap=%h", t, bus1.snap);
      @(negedge clk);
      n_checks++;
      if (bus1.snap_valid !== 1'b0 || bus1.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL single_post: valid=%b busy=%b required 0 0", bus1.snap_valid, bus1.busy);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    pat = 64'h5A5A_F0F0_3C3C_9999;
    e = pat & range_mask(6'd3, 6'd40);
    bus.snap_ready = 1'b0;
    run_scan(6'd3, 6'd40, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.start    = (i % 3 == 0);
      bus.first_ch = 6'd7;
      bus.last_ch  = 6'd8;
      @(negedge clk);
      n_checks++;
      if (bus.snap_valid !== 1'b1 || bus.snap !== e || bus.sel !== 6'd40) begin
        n_fail++;
        $display("FAIL bp_stable: cycle %0d valid=%b snap=%h sel=%0d required 1 %h 40",
                 i, bus.snap_valid, bus.snap, bus.sel, e);
      end
    end
    bus.start = 1'b0;
    bus.snap_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.snap_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b busy=%b required 0 0", bus.snap_valid, bus.busy);
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_queue: busy=%b required 0", bus.busy);
    end
    $display("backpressure released, snap=%h", e);
  endtask

  task automatic test_reset_mid_scan();
    int n;
    pat = 64'h1111_2222_3333_4444;
    bus.first_ch = 6'd0;
    bus.last_ch  = 6'd63;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.sel !== 6'd30 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bus.sel !== 6'd30) begin
      n_fail++;
      $display("FAIL abort_reach: sel=%0d required 30", bus.sel);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.sel !== 6'd0 || bus.snap !== 64'd0 || bus.busy !== 1'b0 || bus.snap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: sel=%0d snap=%h busy=%b valid=%b required 0 0 0 0",
               bus.sel, bus.snap, bus.busy, bus.snap_valid);
    end
    $display("reset mid-scan at channel 30");
    pat = 64'h8421_8421_FACE_0001;
    run_scan(6'd0, 6'd63, 1'b1);
  endtask

`ifdef MUX64_SCAN_CONT_EN
  task automatic test_cont();
    logic [63:0] e;
    int          n;
    pat = 64'h0000_0000_0000_03E0;
    bus.cont = 1'b1;
    bus.snap_ready = 1'b1;
    exp_q.push_back(pat & range_mask(6'd5, 6'd9));
    bus.first_ch = 6'd5;
    bus.last_ch  = 6'd9;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n = 0;
      while (bus.snap_valid !== 1'b1 && n < 40) begin
        n_checks++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL cont_busy: snapshot %0d cycle %0d busy=%b required 1", s, n, bus.busy);
        end
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (n != 5 * S_A) begin
        n_fail++;
        $display("FAIL cont_latency: snapshot %0d after %0d cycles required %0d", s, n, 5 * S_A);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (bus.snap !== e) begin
        n_fail++;
        $display("FAIL cont_snap: snapshot %0d snap=%h required %h", s, bus.snap, e);
      end
      $display("cont snapshot %0d snap=%h", s, bus.snap);
      if (s < 2) begin
        pat = (s == 0) ? 64'h0000_0000_0000_0140 : 64'h0000_0000_0000_0220;
        exp_q.push_back(pat & range_mask(6'd5, 6'd9));
      end else begin
        bus.cont = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (s < 2 && (bus.busy !== 1'b1 || bus.snap_valid !== 1'b0 || bus.sel !== 6'd5 || bus.snap !== 64'd0)) begin
        n_fail++;
        $display("FAIL cont_restart: busy=%b valid=%b sel=%0d snap=%h required 1 0 5 0",
                 bus.busy, bus.snap_valid, bus.sel, bus.snap);
      end else if (s == 2 && bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cont_stop: busy=%b required 0", bus.busy);
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    pat      = '0;
    pat1     = '0;
    bus.start = 1'b0;  bus.first_ch = '0;  bus.last_ch = '0;  bus.snap_ready = 1'b0;
    bus1.start = 1'b0; bus1.first_ch = '0; bus1.last_ch = '0; bus1.snap_ready = 1'b0;
`ifdef MUX64_SCAN_CONT_EN
    bus.cont  = 1'b0;
    bus1.cont = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_full_scan();
    test_wrap();
    test_back_to_back();
    test_single_channel();
    test_backpressure();
    test_reset_mid_scan();
`ifdef MUX64_SCAN_CONT_EN
    test_cont();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
